// File: rtl/morse_pkg.sv
// Shared Morse timing constants and receiver state encoding.
// All durations are expressed in units of one dot length.
package morse_pkg;
    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    localparam int DASH_UNITS       = 2;
    localparam int LETTER_GAP_UNITS = 2;
    localparam int WORD_GAP_UNITS   = 5;
    localparam int MAX_ELEMS_DEF    = 5;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MARK      = 2'd1,
        ST_SPACE     = 2'd2,
        ST_WAIT_WORD = 2'd3
    } state_t;

    function automatic int dur_width(input int unit_ticks);
        return $clog2(WORD_GAP_UNITS * unit_ticks + 1);
    endfunction
endpackage

// File: rtl/morse_dur_counter.sv
// Saturating duration counter; cleared by clr, otherwise +1 per cycle up to a word gap.
// Latency: count reflects clr one cycle later; no backpressure.
module morse_dur_counter
    import morse_pkg::*;
#(
    parameter int UNIT_TICKS = 16,
    parameter int CW         = dur_width(UNIT_TICKS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic [CW-1:0] cnt
);
    localparam logic [CW-1:0] CNT_MAX = CW'(WORD_GAP_UNITS * UNIT_TICKS);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/morse_receiver.sv
// Morse line decoder: one code per letter, error pulse on overlong letters, word-gap pulse.
// Latency: 2-cycle synchroniser, pulses 1 cycle after a gap threshold; no backpressure.
module morse_receiver
    import morse_pkg::*;
#(
    parameter int UNIT_TICKS = 16,
    parameter int MAX_ELEMS  = MAX_ELEMS_DEF
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           key_in,
    output logic                           sym_valid,
    output logic [MAX_ELEMS-1:0]           sym_bits,
    output logic [$clog2(MAX_ELEMS+1)-1:0] sym_len,
    output logic                           sym_err,
    output logic                           word_gap
);
    localparam int CW = dur_width(UNIT_TICKS);
    localparam int LW = $clog2(MAX_ELEMS + 1);
    // dur reads length-1 on the cycle a level is judged, hence the -1 on each threshold.
    localparam logic [CW-1:0] DASH_LAST   = CW'(DASH_UNITS * UNIT_TICKS - 1);
    localparam logic [CW-1:0] LETTER_LAST = CW'(LETTER_GAP_UNITS * UNIT_TICKS - 1);
    localparam logic [CW-1:0] WORD_LAST   = CW'(WORD_GAP_UNITS * UNIT_TICKS - 1);
    localparam logic [LW-1:0] ELEMS_FULL  = LW'(MAX_ELEMS);

    logic                 key_m_q, key_m_d, key_s_q, key_s_d, key_p_q, key_p_d;
    logic [CW-1:0]        dur;
    state_t               state_q, state_d;
    logic [MAX_ELEMS-1:0] elems_q, elems_d;
    logic [LW-1:0]        elem_cnt_q, elem_cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 sym_valid_q, sym_valid_d;
    logic                 sym_err_q, sym_err_d;
    logic                 word_gap_q, word_gap_d;
    logic [MAX_ELEMS-1:0] sym_bits_q, sym_bits_d;
    logic [LW-1:0]        sym_len_q, sym_len_d;

    morse_dur_counter #(
        .UNIT_TICKS(UNIT_TICKS),
        .CW        (CW)
    ) u_dur (
        .clk  (CLK),
        .rst_n(RST),
        .clr  (key_s_q ^ key_p_q),
        .cnt  (dur)
    );

    always_comb begin
        key_m_d     = key_in;
        key_s_d     = key_m_q;
        key_p_d     = key_s_q;
        state_d     = state_q;
        elems_d     = elems_q;
        elem_cnt_d  = elem_cnt_q;
        ovf_d       = ovf_q;
        sym_valid_d = 1'b0;
        sym_err_d   = 1'b0;
        word_gap_d  = 1'b0;
        sym_bits_d  = sym_bits_q;
        sym_len_d   = sym_len_q;

        case (state_q)
            ST_IDLE: begin
                if (key_s_q) begin
                    state_d    = ST_MARK;
                    elems_d    = '0;
                    elem_cnt_d = '0;
                    ovf_d      = 1'b0;
                end
            end
            ST_MARK: begin
                if (!key_s_q) begin
                    if (elem_cnt_q == ELEMS_FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        for (int i = 0; i < MAX_ELEMS; i++) begin
                            if (elem_cnt_q == LW'(i)) begin
                                elems_d[i] = (dur >= DASH_LAST) ? DASH : DOT;
                            end
                        end
                        elem_cnt_d = elem_cnt_q + LW'(1);
                    end
                    state_d = ST_SPACE;
                end
            end
            ST_SPACE: begin
                // Threshold is tested before key_s so a coincident mark cannot extend the letter.
                if (dur >= LETTER_LAST) begin
                    if (ovf_q) begin
                        sym_err_d = 1'b1;
                    end else begin
                        sym_valid_d = 1'b1;
                        sym_bits_d  = elems_q;
                        sym_len_d   = elem_cnt_q;
                    end
                    elems_d    = '0;
                    elem_cnt_d = '0;
                    ovf_d      = 1'b0;
                    state_d    = ST_WAIT_WORD;
                end else if (key_s_q) begin
                    state_d = ST_MARK;
                end
            end
            ST_WAIT_WORD: begin
                if (dur >= WORD_LAST) begin
                    word_gap_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (key_s_q) begin
                    state_d = ST_MARK;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            key_m_q     <= 1'b0;
            key_s_q     <= 1'b0;
            key_p_q     <= 1'b0;
            state_q     <= ST_IDLE;
            elems_q     <= '0;
            elem_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            sym_valid_q <= 1'b0;
            sym_err_q   <= 1'b0;
            word_gap_q  <= 1'b0;
            sym_bits_q  <= '0;
            sym_len_q   <= '0;
        end else begin
            key_m_q     <= key_m_d;
            key_s_q     <= key_s_d;
            key_p_q     <= key_p_d;
            state_q     <= state_d;
            elems_q     <= elems_d;
            elem_cnt_q  <= elem_cnt_d;
            ovf_q       <= ovf_d;
            sym_valid_q <= sym_valid_d;
            sym_err_q   <= sym_err_d;
            word_gap_q  <= word_gap_d;
            sym_bits_q  <= sym_bits_d;
            sym_len_q   <= sym_len_d;
        end
    end

    assign sym_valid = sym_valid_q;
    assign sym_err   = sym_err_q;
    assign word_gap  = word_gap_q;
    assign sym_bits  = sym_bits_q;
    assign sym_len   = sym_len_q;
endmodule

// File: tb/tb_morse_receiver.sv
// Bench for morse_receiver at UNIT_TICKS=4: directed cases plus random letters,
// each key sequence decoded by a run-length model and compared event by event.
module tb_morse_receiver;
    localparam int U      = 4;
    localparam int K_SYM  = 0;
    localparam int K_ERR  = 1;
    localparam int K_WORD = 2;

    logic       CLK = 1'b0;
    logic       RST;
    logic       key_in;
    logic       sym_valid, sym_err, word_gap;
    logic [4:0] sym_bits;
    logic [2:0] sym_len;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         act_kind[$];
    logic [4:0] act_bits[$];
    logic [2:0] act_len[$];
    int         act_cyc[$];
    int         exp_kind[$];
    logic [4:0] exp_bits[$];
    logic [2:0] exp_len[$];
    int         seg_q[$];
    logic [4:0] m_bits;
    logic [2:0] m_len;

    morse_receiver #(.UNIT_TICKS(U), .MAX_ELEMS(5)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .key_in   (key_in),
        .sym_valid(sym_valid),
        .sym_bits (sym_bits),
        .sym_len  (sym_len),
        .sym_err  (sym_err),
        .word_gap (word_gap)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (sym_valid) begin
            act_kind.push_back(K_SYM); act_bits.push_back(sym_bits);
            act_len.push_back(sym_len); act_cyc.push_back(cyc);
        end
        if (sym_err) begin
            act_kind.push_back(K_ERR); act_bits.push_back(5'd0);
            act_len.push_back(3'd0); act_cyc.push_back(cyc);
        end
        if (word_gap) begin
            act_kind.push_back(K_WORD); act_bits.push_back(5'd0);
            act_len.push_back(3'd0); act_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic drive_segs();
        for (int i = 0; i < seg_q.size(); i++) begin
            key_in = (i % 2 == 0);
            repeat (seg_q[i]) @(negedge CLK);
        end
        key_in = 1'b0;
    endtask

    // Segments alternate mark, gap, mark, gap... lengths in cycles.
    task automatic model_segs();
        int         n;
        logic [4:0] bits;
        n    = 0;
        bits = '0;
        for (int i = 0; i + 1 < seg_q.size(); i += 2) begin
            if (n < 5 && seg_q[i] >= 2 * U) bits[n] = 1'b1;
            n++;
            if (seg_q[i+1] >= 2 * U) begin
                if (n > 5) begin
                    exp_kind.push_back(K_ERR); exp_bits.push_back(5'd0); exp_len.push_back(3'd0);
                end else begin
                    exp_kind.push_back(K_SYM); exp_bits.push_back(bits); exp_len.push_back(3'(n));
                    m_bits = bits;
                    m_len  = 3'(n);
                end
                n    = 0;
                bits = '0;
                if (seg_q[i+1] >= 5 * U) begin
                    exp_kind.push_back(K_WORD); exp_bits.push_back(5'd0); exp_len.push_back(3'd0);
                end
            end
        end
    endtask

    task automatic compare_events(input string tag);
        int n;
        chk($sformatf("%s_count", tag), act_kind.size(), exp_kind.size());
        n = (act_kind.size() < exp_kind.size()) ? act_kind.size() : exp_kind.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_kind%0d", tag, i), act_kind[i], exp_kind[i]);
            chk($sformatf("%s_bits%0d", tag, i), act_bits[i], exp_bits[i]);
            chk($sformatf("%s_len%0d", tag, i), act_len[i], exp_len[i]);
        end
        chk($sformatf("%s_hold_bits", tag), sym_bits, m_bits);
        chk($sformatf("%s_hold_len", tag), sym_len, m_len);
        act_kind.delete(); act_bits.delete(); act_len.delete(); act_cyc.delete();
        exp_kind.delete(); exp_bits.delete(); exp_len.delete();
        seg_q.delete();
    endtask

    task automatic run(input string tag);
        drive_segs();
        model_segs();
        compare_events(tag);
    endtask

    initial begin
        int n_el;
        RST    = 1'b0;
        key_in = 1'b0;
        m_bits = '0;
        m_len  = '0;
        repeat (3) @(negedge CLK);
        chk("reset_outputs", {sym_valid, sym_err, word_gap, sym_bits, sym_len}, 0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        seg_q = '{4, 4, 12, 30};        run("letter_A");
        seg_q = '{7, 12};               run("mark7_dot");
        seg_q = '{8, 30};               run("mark8_dash");
        seg_q = '{4, 7, 4, 30};         run("gap7_same");
        seg_q = '{4, 8, 4, 30};         run("gap8_split");

        seg_q = '{4, 4, 4, 4, 4, 40};
        drive_segs();
        chk("word_gap_delay", (act_cyc.size() >= 2) ? act_cyc[1] - act_cyc[0] : -1, 12);
        model_segs();
        compare_events("letter_S_word");
        key_in = 1'b0;
        repeat (40) @(negedge CLK);
        compare_events("idle_quiet");

        seg_q = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 16};
        run("overflow");
        seg_q = '{12, 30};              run("letter_T");

        key_in = 1'b1; repeat (4) @(negedge CLK);
        key_in = 1'b0; repeat (4) @(negedge CLK);
        key_in = 1'b1; repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        key_in = 1'b0;
        chk("reset_mid_outputs", {sym_valid, sym_err, word_gap, sym_bits, sym_len}, 0);
        RST = 1'b1;
        m_bits = '0;
        m_len  = '0;
        repeat (30) @(negedge CLK);
        compare_events("reset_mid_quiet");
        seg_q = '{4, 30};               run("letter_E");

        for (int l = 0; l < 25; l++) begin
            n_el = $urandom_range(1, 6);
            for (int e = 0; e < n_el; e++) begin
                seg_q.push_back($urandom_range(2, 14));
                if (e < n_el - 1) seg_q.push_back($urandom_range(2, 7));
                else              seg_q.push_back($urandom_range(8, 26));
            end
        end
        seg_q[seg_q.size() - 1] = 30;
        run("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
